// File: rtl/cmp_pkg.sv
// Shared definitions for the compare tracker.
//   RES_LT / RES_EQ / RES_GT : one-hot compare result encodings
//   state_t                  : lock FSM state encoding
package cmp_pkg;

    localparam logic [2:0] RES_LT = 3'b001;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_GT = 3'b100;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

endpackage

// File: rtl/compare_core.sv
// Combinational magnitude comparator producing a one-hot result.
// Ports:
//   signed_mode in  0 = unsigned, 1 = two's-complement compare
//   a, b        in  WIDTH-bit operands
//   result      out one-hot {gt, eq, lt}
module compare_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       result
);

    logic lt;
    logic gt;

    always_comb begin
        lt     = 1'b0;
        gt     = 1'b0;
        result = RES_EQ;
        if (signed_mode) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end else begin
            lt = a < b;
            gt = a > b;
        end
        if (lt) begin
            result = RES_LT;
        end else if (gt) begin
            result = RES_GT;
        end
    end

endmodule

// File: rtl/compare_tracker.sv
// Registered comparator with result-stability lock detection and
// saturating per-result event counters.
//
//   state       | meaning
//   ------------+---------------------------------------------------
//   ST_UNLOCKED | result run has not reached HOLD since last change
//   ST_LOCKED   | last HOLD valid results identical; lock_r holds it
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid                 sample a/b/signed_mode this cycle
//   signed_mode, a, b        compare operands and mode
//   clr_cnt                  zero the event counters (wins over a sample)
//   r, r_valid               registered one-hot result and its update pulse
//   stable                   high while locked
//   lock_r                   result captured at the most recent lock
//   change                   pulse on a lock whose result differs from the
//                            previous lock (or the first lock since reset)
//   lt_cnt, eq_cnt, gt_cnt   saturating valid-sample counts per result
module compare_tracker
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_cnt,
    output logic [2:0]       r,
    output logic             r_valid,
    output logic             stable,
    output logic [2:0]       lock_r,
    output logic             change,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt
);

    localparam int                RUN_W   = $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [2:0]       res;
    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic             lock_load;
    logic             change_nxt;
    logic             first_lock;

    compare_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .result      (res)
    );

    // r always holds the previous valid result, so it doubles as the
    // run-comparison reference. After reset r is 000, which never matches
    // a real result, so the first sample starts a run of 1.
    always_comb begin
        state_nxt  = state;
        run_nxt    = run;
        lock_load  = 1'b0;
        change_nxt = 1'b0;
        if (in_valid) begin
            if (res != r) begin
                run_nxt = RUN_W'(1);
            end else if (run != RUN_MAX) begin
                run_nxt = run + 1'b1;
            end
            case (state)
                ST_UNLOCKED: begin
                    if (run_nxt == RUN_MAX) begin
                        state_nxt  = ST_LOCKED;
                        lock_load  = 1'b1;
                        change_nxt = first_lock || (res != lock_r);
                    end
                end
                ST_LOCKED: begin
                    if (res != lock_r) begin
                        // With HOLD=1 a differing result relocks at once
                        // instead of passing through UNLOCKED.
                        if (run_nxt == RUN_MAX) begin
                            lock_load  = 1'b1;
                            change_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_UNLOCKED;
                        end
                    end
                end
                default: state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    assign stable = (state == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_UNLOCKED;
            run        <= '0;
            r          <= 3'b000;
            r_valid    <= 1'b0;
            lock_r     <= 3'b000;
            change     <= 1'b0;
            first_lock <= 1'b1;
        end else begin
            state   <= state_nxt;
            run     <= run_nxt;
            r_valid <= in_valid;
            change  <= change_nxt;
            if (in_valid) begin
                r <= res;
            end
            if (lock_load) begin
                lock_r     <= res;
                first_lock <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            lt_cnt <= '0;
            eq_cnt <= '0;
            gt_cnt <= '0;
        end else if (in_valid) begin
            case (res)
                RES_LT:  if (lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + 1'b1;
                RES_EQ:  if (eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
                RES_GT:  if (gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_tracker.sv
module tb_compare_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       signed_mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr_cnt;

    logic [2:0] r, lock_r;
    logic       r_valid, stable, change;
    logic [3:0] lt_cnt, eq_cnt, gt_cnt;

    logic [2:0] r1, lock_r1;
    logic       r_valid1, stable1, change1;
    logic [3:0] lt_cnt1, eq_cnt1, gt_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compare_tracker #(.WIDTH(4), .HOLD(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
        .a(a), .b(b), .clr_cnt(clr_cnt),
        .r(r), .r_valid(r_valid), .stable(stable), .lock_r(lock_r), .change(change),
        .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt)
    );

    compare_tracker #(.WIDTH(4), .HOLD(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .signed_mode(signed_mode),
        .a(a), .b(b), .clr_cnt(clr_cnt),
        .r(r1), .r_valid(r_valid1), .stable(stable1), .lock_r(lock_r1), .change(change1),
        .lt_cnt(lt_cnt1), .eq_cnt(eq_cnt1), .gt_cnt(gt_cnt1)
    );

    typedef struct {
        logic       v;
        logic       sm;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] er;
        logic       erv;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic sm, input logic [3:0] av,
                         input logic [3:0] bv, input logic clr);
        in_valid    = v;
        signed_mode = sm;
        a           = av;
        b           = bv;
        clr_cnt     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 4'd3,  4'd9,  3'b001, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 4'd9,  4'd3,  3'b001, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 4'd9,  4'd3,  3'b100, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 4'd0,  4'd15, 3'b100, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4'd7,  4'd8,  3'b100, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 4'd7,  4'd8,  3'b001, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 4'd15, 4'd15, 3'b010, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 4'd8,  4'd15, 3'b001, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 4'd0,  4'd0,  3'b010, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 4'd15, 4'd0,  3'b100, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 4'd15, 4'd0,  3'b001, 1'b1};

        // Reset held two cycles with in_valid and clr_cnt active.
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'd3, 4'd9, 1'b1);
        drive(1'b1, 1'b0, 4'd3, 4'd9, 1'b1);
        chk("rst_r",       r,       3'b000);
        chk("rst_rvalid",  r_valid, 1'b0);
        chk("rst_stable",  stable,  1'b0);
        chk("rst_lock",    lock_r,  3'b000);
        chk("rst_change",  change,  1'b0);
        chk("rst_lt",      lt_cnt,  4'd0);
        chk("rst_eq",      eq_cnt,  4'd0);
        chk("rst_gt",      gt_cnt,  4'd0);
        rst = 1'b0;

        // Compare function vectors.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].sm, tbl[i].a, tbl[i].b, 1'b0);
            chk($sformatf("vec%0d_r", i),  r,       tbl[i].er);
            chk($sformatf("vec%0d_rv", i), r_valid, tbl[i].erv);
        end
        chk("tbl_lt_cnt", lt_cnt, 4'd5);
        chk("tbl_eq_cnt", eq_cnt, 4'd2);
        chk("tbl_gt_cnt", gt_cnt, 4'd3);
        chk("tbl_stable", stable, 1'b0);

        // Lock on EQ with an idle cycle inside the run, then unlock.
        do_reset();
        drive(1'b1, 1'b0, 4'd6, 4'd6, 1'b0);
        drive(1'b1, 1'b0, 4'd6, 4'd6, 1'b0);
        chk("eq2_stable", stable, 1'b0);
        drive(1'b0, 1'b0, 4'd1, 4'd9, 1'b0);
        chk("idle_stable", stable, 1'b0);
        drive(1'b1, 1'b0, 4'd6, 4'd6, 1'b0);
        chk("eq3_stable", stable, 1'b1);
        chk("eq3_lock",   lock_r, 3'b010);
        chk("eq3_change", change, 1'b1);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("post_change", change, 1'b0);
        chk("post_stable", stable, 1'b1);
        drive(1'b1, 1'b0, 4'd5, 4'd2, 1'b0);
        chk("unlock_stable", stable, 1'b0);
        chk("unlock_lock",   lock_r, 3'b010);
        chk("unlock_r",      r,      3'b100);

        // Counter saturation and clear-with-sample.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 4'd4, 4'd4, 1'b0);
            if (i == 3) chk("sat_change_once", change, 1'b0);
        end
        chk("sat_eq", eq_cnt, 4'd15);
        chk("sat_lt", lt_cnt, 4'd0);
        chk("sat_gt", gt_cnt, 4'd0);
        drive(1'b1, 1'b0, 4'd1, 4'd2, 1'b1);
        chk("clr_eq", eq_cnt, 4'd0);
        chk("clr_lt", lt_cnt, 4'd0);
        chk("clr_gt", gt_cnt, 4'd0);
        chk("clr_r",  r,      3'b001);
        chk("clr_rv", r_valid, 1'b1);
        chk("clr_stable", stable, 1'b0);
        drive(1'b1, 1'b0, 4'd1, 4'd2, 1'b0);
        chk("after_clr_lt", lt_cnt, 4'd1);

        // First lock after reset, relock same value, relock new value.
        do_reset();
        repeat (3) drive(1'b1, 1'b0, 4'd9, 4'd2, 1'b0);
        chk("gt_lock",   lock_r, 3'b100);
        chk("gt_change", change, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'd9, 4'd2, 1'b1);
        rst = 1'b0;
        chk("rst2_lock",   lock_r, 3'b000);
        chk("rst2_stable", stable, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 4'd9, 4'd2, 1'b0);
        chk("relock_stable", stable, 1'b1);
        chk("relock_change", change, 1'b1);
        chk("relock_lock",   lock_r, 3'b100);
        drive(1'b1, 1'b0, 4'd1, 4'd2, 1'b0);
        chk("lt_unlock", stable, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 4'd9, 4'd2, 1'b0);
        chk("same_stable", stable, 1'b1);
        chk("same_change", change, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 4'd2, 4'd2, 1'b0);
        chk("eq_run2_stable", stable, 1'b0);
        drive(1'b1, 1'b0, 4'd2, 4'd2, 1'b0);
        chk("new_change", change, 1'b1);
        chk("new_lock",   lock_r, 3'b010);

        // HOLD=1 instance.
        do_reset();
        drive(1'b1, 1'b0, 4'd1, 4'd5, 1'b0);
        chk("h1_s1_stable", stable1, 1'b1);
        chk("h1_s1_change", change1, 1'b1);
        chk("h1_s1_lock",   lock_r1, 3'b001);
        drive(1'b1, 1'b0, 4'd2, 4'd5, 1'b0);
        chk("h1_s2_stable", stable1, 1'b1);
        chk("h1_s2_change", change1, 1'b0);
        drive(1'b1, 1'b0, 4'd7, 4'd5, 1'b0);
        chk("h1_s3_stable", stable1, 1'b1);
        chk("h1_s3_change", change1, 1'b1);
        chk("h1_s3_lock",   lock_r1, 3'b100);
        drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        chk("h1_idle_change", change1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
